// File: rtl/pm_resp.sv
// rtl/pm_resp.sv - program-memory responder with instruction fetch port and host boot-load FSM
module pm_resp #(
  parameter int          ADDR_W = 8,
  parameter logic [31:0] NOP_OP = 32'h0
) (
  input  logic        clk_fetch,
  input  logic        rst,
  input  logic        ps_pm_cslt,
  input  logic        ps_pm_wrb,
  input  logic [15:0] ps_pm_add,
  output logic [31:0] pm_ps_op,
  output logic        pm_ps_rdy,
  output logic        pm_ps_oor,
  input  logic        host_pm_start,
  input  logic [15:0] host_pm_len,
  input  logic        host_pm_vld,
  input  logic [15:0] host_pm_dt,
  output logic        pm_host_rdy,
  output logic        pm_boot_done,
  output logic        pm_boot_err
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD_HI = 2'd1,
    S_LOAD_LO = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state;
  logic [31:0]         mem [DEPTH];
  logic [15:0]         len_q;
  logic [ADDR_W-1:0]   cnt;
  logic [15:0]         hi_q;
  logic                last_word;
  logic                add_oor;
  logic                wr_en;

  // The sequencer may drive its write strobe, but program memory is read-only from that side.
  logic unused_wrb;
  assign unused_wrb = ps_pm_wrb;

  // A load ends on the requested count or when the array is full, whichever comes first.
  assign last_word = (16'(cnt) == (len_q - 16'd1)) || (cnt == {ADDR_W{1'b1}});
  assign add_oor   = (ps_pm_add >> ADDR_W) != 16'd0;
  assign wr_en     = !rst && (state == S_LOAD_LO) && host_pm_vld;

  // Boot-load FSM with its handshake/status outputs registered alongside each transition.
  always_ff @(posedge clk_fetch) begin
    if (rst) begin
      state        <= S_IDLE;
      len_q        <= 16'd0;
      cnt          <= '0;
      hi_q         <= 16'd0;
      pm_ps_rdy    <= 1'b1;
      pm_host_rdy  <= 1'b0;
      pm_boot_done <= 1'b0;
      pm_boot_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (host_pm_start) begin
            len_q       <= host_pm_len;
            cnt         <= '0;
            pm_boot_err <= {1'b0, host_pm_len} > DEPTH_W;
            pm_ps_rdy   <= 1'b0;
            if (host_pm_len == 16'd0) begin
              state        <= S_DONE;
              pm_boot_done <= 1'b1;
              pm_host_rdy  <= 1'b0;
            end else begin
              state       <= S_LOAD_HI;
              pm_host_rdy <= 1'b1;
            end
          end
        end
        S_LOAD_HI: begin
          if (host_pm_vld) begin
            hi_q  <= host_pm_dt;
            state <= S_LOAD_LO;
          end
        end
        S_LOAD_LO: begin
          if (host_pm_vld) begin
            cnt <= cnt + 1'b1;
            if (last_word) begin
              state        <= S_DONE;
              pm_boot_done <= 1'b1;
              pm_host_rdy  <= 1'b0;
            end else begin
              state <= S_LOAD_HI;
            end
          end
        end
        S_DONE: begin
          state        <= S_IDLE;
          pm_boot_done <= 1'b0;
          pm_ps_rdy    <= 1'b1;
        end
        default: begin
          state        <= S_IDLE;
          pm_boot_done <= 1'b0;
          pm_host_rdy  <= 1'b0;
          pm_ps_rdy    <= 1'b1;
        end
      endcase
    end
  end

  // Instruction array write: a word lands when its lower half is accepted.
  always_ff @(posedge clk_fetch) begin
    if (wr_en) begin
      mem[cnt] <= {hi_q, host_pm_dt};
    end
  end

  // Fetch port: serve one-cycle-latency reads in IDLE, otherwise force NOP.
  always_ff @(posedge clk_fetch) begin
    if (rst) begin
      pm_ps_op  <= NOP_OP;
      pm_ps_oor <= 1'b0;
    end else if (state != S_IDLE) begin
      pm_ps_op  <= NOP_OP;
      pm_ps_oor <= 1'b0;
    end else if (ps_pm_cslt) begin
      pm_ps_oor <= add_oor;
      pm_ps_op  <= add_oor ? NOP_OP : mem[ps_pm_add[ADDR_W-1:0]];
    end else begin
      pm_ps_oor <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pm_resp.sv
// tb/tb_pm_resp.sv - randomized self-checking bench for pm_resp against a word-level memory model
module tb_pm_resp;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0;

  logic        clk_fetch = 1'b0;
  logic        rst;
  logic        ps_pm_cslt;
  logic        ps_pm_wrb;
  logic [15:0] ps_pm_add;
  logic [31:0] pm_ps_op;
  logic        pm_ps_rdy;
  logic        pm_ps_oor;
  logic        host_pm_start;
  logic [15:0] host_pm_len;
  logic        host_pm_vld;
  logic [15:0] host_pm_dt;
  logic        pm_host_rdy;
  logic        pm_boot_done;
  logic        pm_boot_err;

  pm_resp #(.ADDR_W(8), .NOP_OP(32'h0)) dut (
    .clk_fetch    (clk_fetch),
    .rst          (rst),
    .ps_pm_cslt   (ps_pm_cslt),
    .ps_pm_wrb    (ps_pm_wrb),
    .ps_pm_add    (ps_pm_add),
    .pm_ps_op     (pm_ps_op),
    .pm_ps_rdy    (pm_ps_rdy),
    .pm_ps_oor    (pm_ps_oor),
    .host_pm_start(host_pm_start),
    .host_pm_len  (host_pm_len),
    .host_pm_vld  (host_pm_vld),
    .host_pm_dt   (host_pm_dt),
    .pm_host_rdy  (pm_host_rdy),
    .pm_boot_done (pm_boot_done),
    .pm_boot_err  (pm_boot_err)
  );

  always #5 clk_fetch = ~clk_fetch;

  // reference model: array contents, which words are known, sticky error, expected fetch output
  logic [31:0] mem_m [DEPTH];
  bit          known_m [DEPTH];
  bit          err_m;
  logic [31:0] exp_op;
  bit          exp_known;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_fetch);
    #1;
  endtask

  task automatic start_load(input int len, input bit with_fetch, input int faddr);
    host_pm_start = 1'b1;
    host_pm_len   = 16'(len);
    if (with_fetch) begin
      ps_pm_cslt = 1'b1;
      ps_pm_add  = 16'(faddr);
    end
    tick();
    host_pm_start = 1'b0;
    host_pm_len   = 16'($urandom);
    ps_pm_cslt    = 1'b0;
    err_m = (len > DEPTH);
    check("boot_err_start", {31'd0, pm_boot_err}, {31'd0, err_m});
    check("ps_rdy_start", {31'd0, pm_ps_rdy}, 32'd0);
    if (with_fetch) begin
      exp_op = mem_m[faddr];
      check("fetch_with_start", pm_ps_op, exp_op);
    end
    if (len == 0) begin
      check("done_len0", {31'd0, pm_boot_done}, 32'd1);
      check("host_rdy_len0", {31'd0, pm_host_rdy}, 32'd0);
      tick();
      check("done_len0_end", {31'd0, pm_boot_done}, 32'd0);
      check("ps_rdy_len0_end", {31'd0, pm_ps_rdy}, 32'd1);
    end else begin
      check("host_rdy_start", {31'd0, pm_host_rdy}, 32'd1);
    end
    exp_op = NOP;
    exp_known = 1'b1;
  endtask

  task automatic send_word(input int idx, input logic [31:0] w, input bit inject);
    for (int h = 0; h < 2; h++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (inject && h == 0 && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin
        host_pm_vld = 1'b0;
        host_pm_dt  = 16'($urandom);
        if (inject && h == 0) begin
          host_pm_start = 1'b1;
          host_pm_len   = 16'd1;
        end
        tick();
        host_pm_start = 1'b0;
        check("host_rdy_gap", {31'd0, pm_host_rdy}, 32'd1);
        check("done_gap", {31'd0, pm_boot_done}, 32'd0);
      end
      check("host_rdy_pre", {31'd0, pm_host_rdy}, 32'd1);
      host_pm_vld = 1'b1;
      host_pm_dt  = (h == 0) ? w[31:16] : w[15:0];
      tick();
      host_pm_vld = 1'b0;
      check("op_nop_load", pm_ps_op, NOP);
    end
    mem_m[idx]   = w;
    known_m[idx] = 1'b1;
  endtask

  task automatic end_load(input int len);
    check("done_pulse", {31'd0, pm_boot_done}, 32'd1);
    check("host_rdy_done", {31'd0, pm_host_rdy}, 32'd0);
    check("ps_rdy_done", {31'd0, pm_ps_rdy}, 32'd0);
    // hosts that over-ran the array keep offering data; none may be accepted
    host_pm_vld = (len > DEPTH);
    host_pm_dt  = 16'($urandom);
    tick();
    check("done_once", {31'd0, pm_boot_done}, 32'd0);
    check("ps_rdy_back", {31'd0, pm_ps_rdy}, 32'd1);
    check("host_rdy_idle", {31'd0, pm_host_rdy}, 32'd0);
    check("boot_err_end", {31'd0, pm_boot_err}, {31'd0, err_m});
    host_pm_vld = 1'b0;
  endtask

  task automatic full_load(input int len, input bit inject);
    int n;
    start_load(len, 1'b0, 0);
    if (len != 0) begin
      n = (len > DEPTH) ? DEPTH : len;
      for (int i = 0; i < n; i++) begin
        send_word(i, $urandom, inject && i == 0);
        if (i < n - 1) check("done_early", {31'd0, pm_boot_done}, 32'd0);
      end
      end_load(len);
    end
  endtask

  task automatic fetch(input int addr, input bit wrb);
    ps_pm_cslt = 1'b1;
    ps_pm_wrb  = wrb;
    ps_pm_add  = 16'(addr);
    tick();
    ps_pm_cslt = 1'b0;
    ps_pm_wrb  = 1'b0;
    if (addr >= DEPTH) begin
      exp_op = NOP;
      exp_known = 1'b1;
    end else if (known_m[addr]) begin
      exp_op = mem_m[addr];
      exp_known = 1'b1;
    end else begin
      exp_known = 1'b0;
    end
    check("oor", {31'd0, pm_ps_oor}, {31'd0, addr >= DEPTH});
    if (exp_known) check("fetch_op", pm_ps_op, exp_op);
  endtask

  task automatic hold();
    ps_pm_cslt = 1'b0;
    ps_pm_wrb  = 1'($urandom);
    ps_pm_add  = 16'($urandom);
    tick();
    ps_pm_wrb  = 1'b0;
    check("oor_hold", {31'd0, pm_ps_oor}, 32'd0);
    if (exp_known) check("hold_op", pm_ps_op, exp_op);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
    err_m = 1'b0;
    rst = 1'b1;
    ps_pm_cslt = 1'b0;
    ps_pm_wrb = 1'b0;
    ps_pm_add = 16'd0;
    host_pm_start = 1'b0;
    host_pm_len = 16'd0;
    host_pm_vld = 1'b0;
    host_pm_dt = 16'd0;
    tick();
    tick();
    check("rst_op", pm_ps_op, NOP);
    check("rst_ps_rdy", {31'd0, pm_ps_rdy}, 32'd1);
    check("rst_oor", {31'd0, pm_ps_oor}, 32'd0);
    check("rst_host_rdy", {31'd0, pm_host_rdy}, 32'd0);
    check("rst_done", {31'd0, pm_boot_done}, 32'd0);
    check("rst_err", {31'd0, pm_boot_err}, 32'd0);
    rst = 1'b0;
    exp_op = NOP;
    exp_known = 1'b1;

    // directed three-word load with gaps, then back-to-back fetches
    start_load(3, 1'b0, 0);
    send_word(0, 32'h12345678, 1'b0);
    send_word(1, 32'h9ABCDEF0, 1'b0);
    send_word(2, 32'h00010002, 1'b0);
    end_load(3);
    fetch(0, 1'b0);
    fetch(1, 1'b0);
    fetch(2, 1'b0);
    hold();
    hold();

    // out-of-range fetch, then a write-strobed fetch must not alter the array
    fetch(16'h0100, 1'b0);
    hold();
    fetch(16'hFFFF, 1'b0);
    fetch(1, 1'b1);
    fetch(1, 1'b0);

    // fetch in the same cycle as start is served, then NOP while loading
    start_load(2, 1'b1, 2);
    send_word(0, $urandom, 1'b0);
    send_word(1, $urandom, 1'b0);
    end_load(2);

    // random loads (some with an ignored start mid-load) and random fetches
    for (int r = 0; r < 6; r++) begin
      full_load($urandom_range(1, 20), 1'($urandom));
      for (int k = 0; k < 10; k++) begin
        if ($urandom_range(0, 3) == 0) fetch($urandom_range(0, 65535), 1'($urandom));
        else fetch($urandom_range(0, 31), 1'($urandom));
        if ($urandom_range(0, 2) == 0) hold();
      end
    end

    // oversize load fills the array, flags error, cleared by the next start
    full_load(300, 1'b0);
    fetch(0, 1'b0);
    fetch(255, 1'b0);
    fetch(128, 1'b0);
    full_load(1, 1'b0);
    fetch(0, 1'b0);

    // reset partway through a load keeps the words already written
    start_load(5, 1'b0, 0);
    send_word(0, $urandom, 1'b0);
    send_word(1, $urandom, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    err_m = 1'b0;
    exp_op = NOP;
    exp_known = 1'b1;
    check("midrst_ps_rdy", {31'd0, pm_ps_rdy}, 32'd1);
    check("midrst_host_rdy", {31'd0, pm_host_rdy}, 32'd0);
    check("midrst_done", {31'd0, pm_boot_done}, 32'd0);
    fetch(0, 1'b0);
    fetch(1, 1'b0);

    // zero-length load: done pulse, no writes
    start_load(0, 1'b0, 0);
    fetch(0, 1'b0);
    fetch(1, 1'b0);
    fetch(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
